ltc2324_capture_ctrl: RTL and testbench
=======================================

# ltc2324_capture_ctrl

Capture sequencer for the LTC2324-16 four-channel sampler. It starts and stops the sampler's free-running conversion loop, decimates and counts sample sets, and buffers them in a FIFO. It packs the enabled channels into a 32-bit AXI-Stream toward the DMA, framing each capture with `tlast`. It sits between the register/control interface and the DMA S2MM port, in the same 110 MHz `clk` domain as the sampler.

## Interface
- `FIFO_DEPTH`, 16: sample-set FIFO depth in entries of 4×16 bit; power of two, ≥ 4.
- `clk  in  1`: system clock, shared with the sampler.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `start  in  1`: one-cycle pulse; starts a capture. Honoured only in IDLE.
- `stop  in  1`: one-cycle pulse; aborts the capture. Honoured only in RUN.
- `frame_len  in  16`: sample sets per frame; 0 = continuous. Latched at start.
- `decim  in  8`: keep 1 of every `decim+1` sampler outputs. Latched at start.
- `ch_mask  in  4`: bit i enables channel i+1. Latched at start. A value of 0 causes start to be ignored.
- `sample_en  out  1`: to the sampler `sample_en`; registered.
- `adc_valid  in  1`: sampler `valid`; a one-cycle pulse.
- `adc_ch1..adc_ch4  in  16 each`: sampler channel data, valid while `adc_valid`=1.
- `m_axis_tdata  out  32`, `m_axis_tvalid  out  1`, `m_axis_tlast  out  1`, `m_axis_tready  in  1`: AXI-Stream master.
- `busy  out  1`: state ≠ IDLE.
- `overflow  out  1`: sticky; a sample set was dropped because the FIFO was full. Cleared on an accepted start.
- `frame_done  out  1`: one-cycle pulse when a frame of `frame_len` sets has been completely sent.

## Operation
- **States:**
  - IDLE → RUN on `start` (with `ch_mask`≠0). The controller latches its configuration and clears the decimation counter, set counter, `overflow` and `stop_pending`.
  - RUN: `sample_en`=1.
  - RUN → DRAIN after the `frame_len`-th accepted set, or when an abort completes.
  - DRAIN → IDLE when the FIFO is empty and the serializer is idle.
- **Decimation:** `dcnt` counts `adc_valid` pulses modulo `decim+1`. The pulse with `dcnt`=0 is accepted; the others are discarded. `decim`=0 accepts every pulse.
- **Accepted set:**
  - If the FIFO is not full, the set is written as {ch4,ch3,ch2,ch1} and `scnt` increments.
  - If the FIFO is full, the set is dropped, `overflow` is set, and `scnt` does not increment.
- **Frame end:** when `frame_len`≠0 and `scnt` reaches `frame_len`, `sample_en` drops on the next cycle. The sampler finishes its current period and idles. `adc_valid` pulses outside RUN are ignored.
- **Abort:**
  - `stop` sets `stop_pending`. `sample_en` is held until the next `adc_valid` so the CNV pulse in flight is never truncated.
  - That `adc_valid` is discarded, `sample_en` drops, and the state goes to DRAIN.
  - An aborted frame emits no `tlast` on any word and no `frame_done`.
- **Packing:**
  - The enabled channels, ascending, are packed as 16-bit halves: first channel in [15:0], second in [31:16].
  - A set produces ceil(n/2) words, where n is the number of enabled channels. An odd final half is padded with 0 in [31:16].
  - Example: mask 1011 gives {ch2,ch1}, {0,ch4}.
- **tlast:** asserted on the last word of the `frame_len`-th set only. It is never asserted when `frame_len`=0.
- **frame_done:** pulses when that `tlast` word handshakes.
- A `start` outside IDLE and a `stop` outside RUN are ignored. A simultaneous `start`+`stop` in IDLE is treated as start only.

## Timing
- **Reset values:** `sample_en`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `busy`=0, `overflow`=0, `frame_done`=0. FIFO empty, state IDLE.
- **Reset mid-capture:** `rst_n` low during a capture clears everything immediately and leaves no partial-word residue.
- **start:** `sample_en` and `busy` rise 1 cycle after the start pulse.
- **Sampler output to stream:**
  - FIFO write happens on the `adc_valid` cycle.
  - The first word's `tvalid` appears 2 cycles after `adc_valid` when the FIFO was empty and the serializer idle.
  - Words of one set are issued back-to-back, 1 per cycle, while `tready`=1.
- **AXIS rule:** `tdata` and `tlast` are held stable while `tvalid`=1 and `tready`=0. `tvalid` never drops without a handshake.
- **Frame end:** `sample_en` falls 1 cycle after the final accepted `adc_valid`.
- **IDLE return:** `busy` falls 1 cycle after the last handshake, coincident with `frame_done`.
- **Throughput margin:** at 2 Msps there are 55 cycles per set and at most 2 words per set, so overflow requires sustained back-pressure.

## Test plan
- **Frame, all channels:** mask 1111, decim 0, frame_len 3, tready=1, sampler model with 55-cycle period → 6 words. `tlast` on word 6 only, then `frame_done`. `sample_en` is high for exactly 3 valids.
- **Decimation and odd mask:** decim 2, mask 0101, frame_len 2 → valids #0 and #3 accepted. Words are {ch3,ch1}; `tlast` on the second word.
- **Back-pressure and overflow:** mask 1111, FIFO_DEPTH 4, `tready`=0 for 8 sets, then 1 → exactly 4 sets (8 words) are emitted and `overflow`=1. A new start clears `overflow`.
- **Abort:** in continuous mode (frame_len 0), `stop` mid-period → `sample_en` drops the cycle after the next `adc_valid`, and that set is not emitted. No `tlast`, no `frame_done`; `busy` falls after the drain.
- **Ignored controls:** `start` with `ch_mask`=0 → stays IDLE. `start` during RUN → no effect. `stop` in IDLE → no effect.
- **Async reset:** `rst_n` low with a stalled word pending → all outputs are 0 immediately. After release, a normal frame is emitted cleanly.

Source files
------------

// File: rtl/ltc2324_capture_ctrl.sv
// LTC2324-16 capture sequencer: start/stop control, decimation, sample-set FIFO
// and channel packing onto a 32-bit AXI-Stream with per-frame tlast.
module ltc2324_capture_ctrl #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] frame_len,
  input  logic [7:0]  decim,
  input  logic [3:0]  ch_mask,
  output logic        sample_en,
  input  logic        adc_valid,
  input  logic [15:0] adc_ch1,
  input  logic [15:0] adc_ch2,
  input  logic [15:0] adc_ch3,
  input  logic [15:0] adc_ch4,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        busy,
  output logic        overflow,
  output logic        frame_done
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  state_t r_state, w_state_nxt;

  logic [64:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr, r_rd, w_rd_nxt;
  logic [15:0]   r_flen, r_scnt;
  logic [7:0]    r_decim, r_dcnt;
  logic [3:0]    r_mask;
  logic          r_stop_pend, r_ovf, r_sample_en;
  logic          r_tvalid, r_tlast, r_last_of_set, r_fd;
  logic [31:0]   r_tdata;

  logic          w_start_ok, w_run_valid, w_abort, w_accept, w_full, w_push;
  logic          w_frame_end, w_hs, w_pop, w_adv, w_cont, w_load, w_two;
  logic [64:0]   w_head;
  logic [15:0]   w_h [4];
  logic [2:0]    w_n;

  assign w_start_ok  = (r_state == S_IDLE) && start && (ch_mask != '0);
  assign w_run_valid = (r_state == S_RUN) && adc_valid;
  assign w_abort     = w_run_valid && r_stop_pend;
  assign w_accept    = w_run_valid && !r_stop_pend && (r_dcnt == '0);
  assign w_full      = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push      = w_accept && !w_full;
  assign w_frame_end = w_push && (r_flen != '0) && ((r_scnt + 16'd1) == r_flen);

  // A set stays in the FIFO until its last word handshakes, so the entry on
  // display still counts toward FIFO_DEPTH.
  assign w_hs     = r_tvalid && m_axis_tready;
  assign w_pop    = w_hs && r_last_of_set;
  assign w_rd_nxt = r_rd + {{AW{1'b0}}, w_pop};
  assign w_adv    = !r_tvalid || m_axis_tready;
  assign w_head   = r_mem[w_rd_nxt[AW-1:0]];
  assign w_cont   = r_tvalid && !r_last_of_set;
  assign w_load   = w_adv && (w_cont || (w_rd_nxt != r_wr));

  always_comb begin
    w_h[0] = '0;
    w_h[1] = '0;
    w_h[2] = '0;
    w_h[3] = '0;
    w_n    = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      if (r_mask[j]) begin
        w_h[w_n[1:0]] = w_head[16*j +: 16];
        w_n           = w_n + 3'd1;
      end
    end
  end
  assign w_two = (w_n > 3'd2);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_RUN;
      S_RUN:   if (w_abort || w_frame_end) w_state_nxt = S_DRAIN;
      S_DRAIN: if ((w_rd_nxt == r_wr) && w_adv) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sample_en <= 1'b0;
      r_flen      <= '0;
      r_decim     <= '0;
      r_mask      <= '0;
      r_dcnt      <= '0;
      r_scnt      <= '0;
      r_stop_pend <= 1'b0;
      r_ovf       <= 1'b0;
      r_wr        <= '0;
      r_rd        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sample_en <= (w_state_nxt == S_RUN);
      r_wr        <= r_wr + {{AW{1'b0}}, w_push};
      r_rd        <= w_rd_nxt;
      if (w_start_ok) begin
        r_flen      <= frame_len;
        r_decim     <= decim;
        r_mask      <= ch_mask;
        r_dcnt      <= '0;
        r_scnt      <= '0;
        r_stop_pend <= 1'b0;
        r_ovf       <= 1'b0;
      end else begin
        if ((r_state == S_RUN) && stop) r_stop_pend <= 1'b1;
        if (w_run_valid && !r_stop_pend)
          r_dcnt <= (r_dcnt == r_decim) ? '0 : r_dcnt + 8'd1;
        if (w_accept && w_full) r_ovf <= 1'b1;
        if (w_push) r_scnt <= r_scnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= {w_frame_end, adc_ch4, adc_ch3, adc_ch2, adc_ch1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tvalid      <= 1'b0;
      r_tdata       <= '0;
      r_tlast       <= 1'b0;
      r_last_of_set <= 1'b0;
      r_fd          <= 1'b0;
    end else begin
      r_fd <= w_hs && r_tlast;
      if (w_load) begin
        r_tvalid <= 1'b1;
        if (w_cont) begin
          r_tdata       <= {w_h[3], w_h[2]};
          r_tlast       <= w_head[64];
          r_last_of_set <= 1'b1;
        end else begin
          r_tdata       <= {w_h[1], w_h[0]};
          r_tlast       <= w_head[64] && !w_two;
          r_last_of_set <= !w_two;
        end
      end else if (w_adv) begin
        r_tvalid <= 1'b0;
        r_tdata  <= '0;
        r_tlast  <= 1'b0;
      end
    end
  end

  assign sample_en     = r_sample_en;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign busy          = (r_state != S_IDLE);
  assign overflow      = r_ovf;
  assign frame_done    = r_fd;
endmodule

// File: tb/tb_ltc2324_capture_ctrl.sv
// Bench for ltc2324_capture_ctrl: sampler model, set-level reference model of
// the expected word stream, and a per-cycle stream/handshake checker.
module tb_ltc2324_capture_ctrl;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic [15:0] frame_len = '0;
  logic [7:0]  decim = '0;
  logic [3:0]  ch_mask = '0;
  logic        sample_en, adc_valid = 1'b0;
  logic [15:0] adc_ch1 = '0, adc_ch2 = '0, adc_ch3 = '0, adc_ch4 = '0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready = 1'b0;
  logic        busy, overflow, frame_done;

  always #5 clk = ~clk;

  ltc2324_capture_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .frame_len(frame_len), .decim(decim), .ch_mask(ch_mask),
    .sample_en(sample_en), .adc_valid(adc_valid),
    .adc_ch1(adc_ch1), .adc_ch2(adc_ch2), .adc_ch3(adc_ch3), .adc_ch4(adc_ch4),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .busy(busy), .overflow(overflow), .frame_done(frame_done)
  );

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: what the stream must carry, computed per sampler pulse.
  bit          m_active = 0, m_stop = 0, m_ovf = 0;
  int          m_k = 0, m_cnt = 0, m_pushed = 0, m_room = -1;
  logic [15:0] m_flen = '0;
  logic [7:0]  m_decim = '0;
  logic [3:0]  m_mask = '0;
  logic [32:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [63:0] log_q[$];
  int n_pulse = 0, n_pulse_en = 0, n_hs = 0, n_tlast = 0, n_fd = 0;

  task automatic model_pulse(input logic [63:0] d);
    logic [15:0] h[$];
    int nw;
    logic last;
    log_q.push_back(d);
    if (!m_active) return;
    if (m_stop) begin
      m_active = 0;
      return;
    end
    if (m_k % (int'(m_decim) + 1) == 0) begin
      if (m_room >= 0 && m_pushed >= m_room) m_ovf = 1;
      else begin
        for (int c = 0; c < 4; c++) if (m_mask[c]) h.push_back(d[16*c +: 16]);
        if (h.size() % 2 != 0) h.push_back(16'h0);
        nw = h.size() / 2;
        for (int w = 0; w < nw; w++) begin
          last = (m_flen != 0) && (m_cnt + 1 == int'(m_flen)) && (w == nw - 1);
          exp_q.push_back({last, h[2*w+1], h[2*w]});
        end
        m_pushed++;
        m_cnt++;
        if (m_flen != 0 && m_cnt == int'(m_flen)) m_active = 0;
      end
    end
    m_k++;
  endtask

  // Sampler: one valid pulse per period while sample_en, finishing the period in flight.
  int          period = 55;
  bit          smp_busy = 0;
  logic [63:0] smp_d;
  initial forever begin
    @(posedge clk); #1;
    if (sample_en && rst_n) begin
      smp_busy = 1;
      repeat (period - 2) @(posedge clk);
      #1;
      smp_d = {$urandom, $urandom};
      {adc_ch4, adc_ch3, adc_ch2, adc_ch1} = smp_d;
      adc_valid = 1'b1;
      n_pulse++;
      if (sample_en) n_pulse_en++;
      model_pulse(smp_d);
      @(posedge clk); #1;
      adc_valid = 1'b0;
      smp_busy = 0;
    end
  end

  int tr_mode = 1;  // 0: hold low, 1: hold high, 2: random
  initial forever begin
    @(posedge clk); #1;
    case (tr_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  logic        p_stall = 0, p_last = 0, p_hslast = 0;
  logic [31:0] p_data = '0;
  logic [32:0] e;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      p_stall  = 0;
      p_hslast = 0;
    end else begin
      if (p_stall) begin
        chk("hold_tvalid", m_axis_tvalid, 1'b1);
        chk("hold_tdata", m_axis_tdata, p_data);
        chk("hold_tlast", m_axis_tlast, p_last);
      end
      chk("frame_done_timing", frame_done, p_hslast);
      if (frame_done) n_fd++;
      p_hslast = 0;
      if (m_axis_tvalid && m_axis_tready) begin
        n_hs++;
        got_q.push_back(m_axis_tdata);
        if (m_axis_tlast) n_tlast++;
        p_hslast = m_axis_tlast;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_word: got %0h want no word", m_axis_tdata);
        end else begin
          total--;
          e = exp_q.pop_front();
          chk("tdata", m_axis_tdata, e[31:0]);
          chk("tlast", m_axis_tlast, e[32]);
        end
      end
      p_stall = m_axis_tvalid && !m_axis_tready;
      p_data  = m_axis_tdata;
      p_last  = m_axis_tlast;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] mask, input logic [7:0] dec,
                          input logic [15:0] flen, input bit ok);
    for (int i = 0; i < 500 && smp_busy; i++) tick();
    ch_mask = mask; decim = dec; frame_len = flen;
    start = 1'b1;
    if (ok) begin
      m_active = 1; m_stop = 0; m_k = 0; m_cnt = 0; m_pushed = 0; m_ovf = 0;
      m_flen = flen; m_decim = dec; m_mask = mask;
      log_q.delete();
      got_q.delete();
    end
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy, ok);
    chk("sample_en_after_start", sample_en, ok);
    if (ok) chk("overflow_cleared", overflow, 1'b0);
  endtask

  task automatic wait_idle(input string name, input bit fd_exp);
    int i = 0;
    @(negedge clk);
    while (busy && i < 5000) begin
      @(negedge clk);
      i++;
    end
    chk({name, "_idle"}, busy, 1'b0);
    chk({name, "_fd_with_busy_fall"}, frame_done, fd_exp);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_pulses(input int n);
    int base = n_pulse;
    int i = 0;
    while (n_pulse < base + n && i < 20000) begin
      tick();
      i++;
    end
    chk("pulse_wait", n_pulse >= base + n, 1'b1);
  endtask

  task automatic do_stop();
    int i = 0;
    wait_pulses(1);
    tick(5);
    stop = 1'b1;
    m_stop = 1;
    tick();
    stop = 1'b0;
    @(negedge clk);
    while (!adc_valid && i < 500) begin
      @(negedge clk);
      i++;
    end
    chk("abort_valid_seen", adc_valid, 1'b1);
    chk("en_at_abort_valid", sample_en, 1'b1);
    @(negedge clk);
    chk("en_after_abort_valid", sample_en, 1'b0);
  endtask

  int hs0, tl0, fd0, pe0;
  logic [63:0] s0, s3;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    tick(3);
    @(negedge clk);
    chk("rst_outputs", {sample_en, m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, overflow, frame_done}, '0);
    tick();
    rst_n = 1'b1;
    tick(2);
    @(negedge clk);
    chk("post_rst_outputs", {sample_en, m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, overflow, frame_done}, '0);

    // Ignored controls in IDLE
    stop = 1'b1; tick(); stop = 1'b0;
    @(negedge clk);
    chk("stop_idle_busy", busy, 1'b0);
    do_start(4'b0000, 8'd0, 16'd1, 0);
    tick(2);

    // Full frame, all channels; a start during RUN must change nothing
    period = 55; tr_mode = 1;
    hs0 = n_hs; tl0 = n_tlast; fd0 = n_fd; pe0 = n_pulse_en;
    do_start(4'b1111, 8'd0, 16'd3, 1);
    tick(30);
    ch_mask = 4'b0001; frame_len = 16'd1; start = 1'b1;
    tick(); start = 1'b0;
    wait_idle("frame", 1);
    chk("frame_words", n_hs - hs0, 6);
    chk("frame_tlast_cnt", n_tlast - tl0, 1);
    chk("frame_done_cnt", n_fd - fd0, 1);
    chk("frame_en_valids", n_pulse_en - pe0, 3);
    s3 = log_q[2];
    chk("frame_word6", got_q[5], {s3[63:48], s3[47:32]});

    // Decimation with odd mask
    period = 15;
    hs0 = n_hs; tl0 = n_tlast;
    do_start(4'b0101, 8'd2, 16'd2, 1);
    wait_idle("decim", 1);
    chk("decim_words", n_hs - hs0, 2);
    chk("decim_tlast_cnt", n_tlast - tl0, 1);
    s0 = log_q[0]; s3 = log_q[3];
    chk("decim_word0", got_q[0], {s0[47:32], s0[15:0]});
    chk("decim_word1", got_q[1], {s3[47:32], s3[15:0]});

    // Back-pressure and overflow
    period = 20; tr_mode = 0; m_room = DEPTH;
    hs0 = n_hs; tl0 = n_tlast;
    do_start(4'b1111, 8'd0, 16'd0, 1);
    wait_pulses(8);
    do_stop();
    chk("model_ovf", m_ovf, 1'b1);
    chk("overflow_set", overflow, 1'b1);
    tr_mode = 1;
    wait_idle("ovf", 0);
    chk("ovf_words", n_hs - hs0, 8);
    chk("ovf_no_tlast", n_tlast - tl0, 0);
    chk("overflow_sticky", overflow, 1'b1);
    m_room = -1;

    // Abort in continuous mode with random back-pressure
    period = 14; tr_mode = 2;
    tl0 = n_tlast; fd0 = n_fd;
    do_start(4'($urandom_range(1, 15)), 8'($urandom_range(0, 2)), 16'd0, 1);
    wait_pulses(4);
    do_stop();
    wait_idle("abort", 0);
    chk("abort_no_tlast", n_tlast - tl0, 0);
    chk("abort_no_fd", n_fd - fd0, 0);

    // Async reset with a stalled word pending
    period = 12; tr_mode = 0;
    do_start(4'b1111, 8'd0, 16'd0, 1);
    for (int i = 0; i < 300 && !m_axis_tvalid; i++) @(negedge clk);
    chk("stall_word_present", m_axis_tvalid, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    m_active = 0; m_stop = 0;
    exp_q.delete();
    #1;
    chk("async_rst_outputs", {sample_en, m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, overflow, frame_done}, '0);
    tick(3);
    rst_n = 1'b1;
    tr_mode = 1;
    tick(2);
    do_start(4'b1011, 8'd1, 16'd2, 1);
    wait_idle("post_reset", 1);

    // Randomized frames
    tr_mode = 2;
    for (int r = 0; r < 8; r++) begin
      period = $urandom_range(12, 20);
      fd0 = n_fd;
      do_start(4'($urandom_range(1, 15)), 8'($urandom_range(0, 3)), 16'($urandom_range(1, 4)), 1);
      wait_idle("rand", 1);
      chk("rand_fd_cnt", n_fd - fd0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
